// File: rtl/ccff_chain_loader.sv
// Configuration chain loader: accepts bitstream words over valid/ready and
// shifts exactly CHAIN_LEN bits MSB-first onto the CCFF chain head.
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 100,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  output logic              busy,
  output logic              cfg_done,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic [1:0]        fsm_state
);

  // Handshake: a word transfers on a rising prog_clk edge where bs_valid and
  // bs_ready are both high; bs_ready depends only on the FSM state.
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WLEN = CNT_W'(WORD_W);

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  sreg;
  logic [CNT_W-1:0]   wcnt;
  logic [CNT_W-1:0]   remain;
  logic [CNT_W-1:0]   word_len;
  logic               last_bit;
  logic               chain_last;

  // The final word may be partial: only the bits still owed to the chain are shifted.
  assign remain     = LEN - bit_cnt;
  assign word_len   = (remain > WLEN) ? WLEN : remain;
  assign last_bit   = (wcnt == CNT_W'(1));
  assign chain_last = (bit_cnt == LEN - CNT_W'(1));
  assign fsm_state  = state;

  always_ff @(posedge prog_clk) begin
    if (pReset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bs_ready  = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nxt = FETCH;
      FETCH: begin
        bs_ready = 1'b1;
        if (bs_valid) state_nxt = SHIFT;
      end
      SHIFT: if (last_bit) state_nxt = chain_last ? DONE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sreg      <= '0;
      wcnt      <= '0;
      bit_cnt   <= '0;
      ccff_head <= 1'b0;
      ccff_en   <= 1'b0;
      busy      <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      ccff_head <= 1'b0;
      ccff_en   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            bit_cnt  <= '0;
            cfg_done <= 1'b0;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (bs_valid) begin
            sreg <= bs_data;
            wcnt <= word_len;
          end
        end
        SHIFT: begin
          // head and enable move together so the chain samples one cycle later
          ccff_head <= sreg[WORD_W-1];
          ccff_en   <= 1'b1;
          sreg      <= sreg << 1;
          bit_cnt   <= bit_cnt + CNT_W'(1);
          wcnt      <= wcnt - CNT_W'(1);
          if (last_bit && chain_last) begin
            busy     <= 1'b0;
            cfg_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 20-bit chain and a 16-bit chain share stimulus,
// a monitor scores every enabled chain bit against an expected queue.
module tb_ccff_chain_loader;

  logic        clk = 1'b0;
  logic        p_reset, start, bs_valid, sel;
  logic [7:0]  bs_data;

  logic        r20, h20, e20, b20, d20, r16, h16, e16, b16, d16;
  logic [15:0] c20, c16;
  logic [1:0]  s20, s16;

  logic        bs_ready, ccff_head, ccff_en, busy, cfg_done;
  logic [15:0] bit_cnt;
  logic [1:0]  fsm_state;

  logic [0:0]  exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int          en_cnt = 0, hs_cnt = 0, rdy_cnt = 0;

  always #5 clk = ~clk;

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(16)) u_dut20 (
    .prog_clk(clk), .pReset(p_reset), .start(start & ~sel), .bs_data(bs_data),
    .bs_valid(bs_valid & ~sel), .bs_ready(r20), .ccff_head(h20), .ccff_en(e20),
    .busy(b20), .cfg_done(d20), .bit_cnt(c20), .fsm_state(s20));

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(16), .CNT_W(16)) u_dut16 (
    .prog_clk(clk), .pReset(p_reset), .start(start & sel), .bs_data(bs_data),
    .bs_valid(bs_valid & sel), .bs_ready(r16), .ccff_head(h16), .ccff_en(e16),
    .busy(b16), .cfg_done(d16), .bit_cnt(c16), .fsm_state(s16));

  assign bs_ready  = sel ? r16 : r20;
  assign ccff_head = sel ? h16 : h20;
  assign ccff_en   = sel ? e16 : e20;
  assign busy      = sel ? b16 : b20;
  assign cfg_done  = sel ? d16 : d20;
  assign bit_cnt   = sel ? c16 : c20;
  assign fsm_state = sel ? s16 : s20;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every enabled chain cycle must deliver the next expected bit
  always @(negedge clk) begin
    logic [0:0] e;
    if (ccff_en === 1'b1) begin
      en_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL head_extra: got en=1 expected no more bits at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("ccff_head", 32'(ccff_head), 32'(e));
      end
    end
    if (bs_ready === 1'b1) rdy_cnt++;
    if (bs_valid && bs_ready === 1'b1) hs_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic push_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) exp_q.push_back(w[i]);
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    en_cnt  = 0;
    hs_cnt  = 0;
    rdy_cnt = 0;
  endtask

  // offer one word; with gap>0 the word is withheld for gap cycles of FETCH
  task automatic send_word(input logic [7:0] d, input int gap);
    int k;
    bs_data  = d;
    bs_valid = (gap == 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bs_ready !== 1'b1 && k < 200);
    check("ready_timeout", 32'(bs_ready), 32'd1);
    repeat (gap) begin
      @(negedge clk);
      check("gap_en", 32'(ccff_en), 32'd0);
    end
    bs_valid = 1'b1;
    @(posedge clk);
    #1;
    bs_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (cfg_done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", 32'(cfg_done), 32'd1);
    @(negedge clk);
  endtask

  task automatic finish_checks(input int bits, input int words);
    check("en_count", 32'(en_cnt), 32'(bits));
    check("handshakes", 32'(hs_cnt), 32'(words));
    check("ready_cycles", 32'(rdy_cnt), 32'(words));
    check("bit_cnt", 32'(bit_cnt), 32'(bits));
    check("cfg_done", 32'(cfg_done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("en_done", 32'(ccff_en), 32'd0);
    check("head_done", 32'(ccff_head), 32'd0);
    check("state_done", 32'(fsm_state), 32'd3);
    check("queue_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    p_reset = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = 8'h00; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 p_reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bs_ready), 32'd0);
    check("rst_en", 32'(ccff_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'd0);

    // 1: back-to-back words, low nibble of 0xF0 must never reach the chain
    start_load();
    check("busy_start", 32'(busy), 32'd1);
    push_bits(8'hA5, 8); send_word(8'hA5, 0);
    push_bits(8'h3C, 8); send_word(8'h3C, 0);
    push_bits(8'hF0, 4); send_word(8'hF0, 0);
    wait_done();
    finish_checks(20, 3);

    // 2: stalled words
    start_load();
    push_bits(8'hA5, 8); send_word(8'hA5, 5);
    push_bits(8'h3C, 8); send_word(8'h3C, 5);
    push_bits(8'hF0, 4); send_word(8'hF0, 5);
    wait_done();
    check("en_count_gap", 32'(en_cnt), 32'd20);
    check("bit_cnt_gap", 32'(bit_cnt), 32'd20);
    check("queue_left_gap", 32'(exp_q.size()), 32'd0);

    // 3: start during SHIFT of word 2 is ignored; a fourth word is refused
    start_load();
    push_bits(8'hA5, 8); send_word(8'hA5, 0);
    push_bits(8'h3C, 8); send_word(8'h3C, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    push_bits(8'hF0, 4); send_word(8'hF0, 0);
    wait_done();
    finish_checks(20, 3);
    bs_data  = 8'h77;
    bs_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("ready_after_done", 32'(bs_ready), 32'd0);
    end
    bs_valid = 1'b0;
    check("handshakes_after_done", 32'(hs_cnt), 32'd3);

    // 4: reset after 11 bits, then a clean reload
    start_load();
    push_bits(8'hA5, 8); send_word(8'hA5, 0);
    push_bits(8'h3C, 8); send_word(8'h3C, 0);
    k = 0;
    while (bit_cnt !== 16'd11 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reach_11", 32'(bit_cnt), 32'd11);
    p_reset = 1'b1;
    @(posedge clk);
    #1 p_reset = 1'b0;
    exp_q.delete();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_en", 32'(ccff_en), 32'd0);
    check("mid_rst_bit_cnt", 32'(bit_cnt), 32'd0);
    check("mid_rst_done", 32'(cfg_done), 32'd0);
    check("mid_rst_state", 32'(fsm_state), 32'd0);
    start_load();
    push_bits(8'hA5, 8); send_word(8'hA5, 0);
    push_bits(8'h3C, 8); send_word(8'h3C, 0);
    push_bits(8'hF0, 4); send_word(8'hF0, 0);
    wait_done();
    finish_checks(20, 3);

    // 5: restart from DONE
    start_load();
    check("done_drop", 32'(cfg_done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_bit_cnt", 32'(bit_cnt), 32'd0);
    push_bits(8'h00, 8); send_word(8'h00, 0);
    push_bits(8'hFF, 8); send_word(8'hFF, 0);
    push_bits(8'h80, 4); send_word(8'h80, 0);
    wait_done();
    finish_checks(20, 3);

    // 6: 16-bit chain, exact multiple of the word width
    sel = 1'b1;
    start_load();
    push_bits(8'h12, 8); send_word(8'h12, 0);
    push_bits(8'h34, 8); send_word(8'h34, 0);
    wait_done();
    finish_checks(16, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
